// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the 4-bit ALU decoder: captures A, B and OpCode from the switches on debounced presses.
// Optional ALU_SEQ_LIVE_PREVIEW_EN: the field being loaded follows sw_data every cycle until it is captured.
module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_data,
  input  logic       btn_load,
  input  logic       btn_clear,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] OpCode,
  output logic [1:0] stage,
  output logic       valid
);

  localparam logic [1:0] LOAD_A  = 2'd0;
  localparam logic [1:0] LOAD_B  = 2'd1;
  localparam logic [1:0] LOAD_OP = 2'd2;
  localparam logic [1:0] READY   = 2'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Button index 0 is load, index 1 is clear.
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, rise_s;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       state_q, state_d;
  logic [3:0]       a_q, a_d, b_q, b_d, op_q, op_d;
  logic             valid_q, valid_d;
  logic             load_p, clear_p;

  assign sync1_d = {btn_clear, btn_load};
  assign sync2_d = sync1_q;

  // A pulse is raised in the cycle whose closing edge lifts the debounced level, so the capture lands on that edge.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i]  = cnt_q[i];
      deb_d[i]  = deb_q[i];
      rise_s[i] = 1'b0;
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]  = '0;
        deb_d[i]  = sync2_q[i];
        rise_s[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign load_p  = rise_s[0];
  assign clear_p = rise_s[1];

  // Sequencer next state and field capture; clear takes priority over load.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
    case (state_q)
      LOAD_A:  a_d  = sw_data;
      LOAD_B:  b_d  = sw_data;
      LOAD_OP: op_d = sw_data;
      default: a_d  = a_q;
    endcase
`endif
    if (clear_p) begin
      state_d = LOAD_A;
      a_d     = 4'h0;
      b_d     = 4'h0;
      op_d    = 4'h0;
    end else if (load_p) begin
      case (state_q)
        LOAD_A:  begin a_d  = sw_data; state_d = LOAD_B;  end
        LOAD_B:  begin b_d  = sw_data; state_d = LOAD_OP; end
        LOAD_OP: begin op_d = sw_data; state_d = READY;   end
        READY:   begin a_d  = sw_data; state_d = LOAD_B;  end
        default: state_d = LOAD_A;
      endcase
    end else begin
      state_d = state_q;
    end
    valid_d = (state_d == READY);
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      deb_q    <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      state_q  <= LOAD_A;
      a_q      <= 4'h0;
      b_q      <= 4'h0;
      op_q     <= 4'h0;
      valid_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      deb_q    <= deb_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      valid_q  <= valid_d;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign OpCode = op_q;
  assign stage  = state_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomised self-checking bench for alu_operand_sequencer against a behavioural model of the sequencer.
module tb_alu_operand_sequencer;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw_data = 4'h0;
  logic       btn_load = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] A, B, OpCode;
  logic [1:0] stage;
  logic       valid;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: two-sample input delay, history of synced samples, field array indexed by stage.
  logic           m_dl0 [2];
  logic           m_dl1 [2];
  logic [DEB-1:0] m_hist [2];
  logic           m_deb [2];
  logic [3:0]     m_f [3];
  int             m_stage;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .btn_load(btn_load), .btn_clear(btn_clear),
    .A(A), .B(B), .OpCode(OpCode), .stage(stage), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_dl0[b] = 1'b0; m_dl1[b] = 1'b0; m_hist[b] = '0; m_deb[b] = 1'b0;
    end
    for (int f = 0; f < 3; f++) m_f[f] = 4'h0;
    m_stage = 0;
  endtask

  task automatic model_edge(input logic rl, input logic rc, input logic [3:0] sw);
    logic raw [2];
    bit   rise [2];
    logic s;
    raw[0] = rl; raw[1] = rc;
    for (int b = 0; b < 2; b++) begin
      s = m_dl1[b];
      m_dl1[b] = m_dl0[b];
      m_dl0[b] = raw[b];
      m_hist[b] = {m_hist[b][DEB-2:0], s};
      rise[b] = 1'b0;
      // Level accepted once DEB consecutive synced samples disagree with it.
      if (m_hist[b] == {DEB{~m_deb[b]}}) begin
        m_deb[b] = ~m_deb[b];
        rise[b] = m_deb[b];
      end
    end
`ifdef ALU_SEQ_LIVE_PREVIEW_EN
    if (m_stage < 3) m_f[m_stage] = sw;
`endif
    if (rise[1]) begin
      for (int f = 0; f < 3; f++) m_f[f] = 4'h0;
      m_stage = 0;
    end else if (rise[0]) begin
      if (m_stage == 3) begin
        m_f[0] = sw; m_stage = 1;
      end else begin
        m_f[m_stage] = sw; m_stage = m_stage + 1;
      end
    end
  endtask

  task automatic tick();
    logic rl, rc;
    logic [3:0] sw;
    rl = btn_load; rc = btn_clear; sw = sw_data;
    @(posedge clk);
    if (rst_n) model_edge(rl, rc, sw);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic [3:0] sw, input int hold);
    sw_data = sw; btn_load = 1'b1;
    ticks(hold);
    btn_load = 1'b0;
    ticks(DEB + 4);
  endtask

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("A", int'(A), int'(m_f[0]));
      check("B", int'(B), int'(m_f[1]));
      check("OpCode", int'(OpCode), int'(m_f[2]));
      check("stage", int'(stage), m_stage);
      check("valid", int'(valid), int'(m_stage == 3));
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    ticks(2);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    ticks(2);

    // Reset mid-sequence, asserted between edges.
    press(4'h5, 8);
    check("A_loaded", int'(A), 5);
    check("stage_loaded", int'(stage), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_A", int'(A), 0);
    check("rst_stage", int'(stage), 0);
    check("rst_valid", int'(valid), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);

    // Full set with capture latency DEB+2 after the press edge.
    sw_data = 4'h3; btn_load = 1'b1;
    ticks(DEB + 1);
    check("lat_before_A", int'(A), 0);
    check("lat_before_stage", int'(stage), 0);
    tick();
    check("lat_at_A", int'(A), 3);
    check("lat_at_stage", int'(stage), 1);
    ticks(3);
    btn_load = 1'b0;
    ticks(DEB + 4);
    press(4'h9, 8);
    press(4'h5, 8);
    check("set_A", int'(A), 3);
    check("set_B", int'(B), 9);
    check("set_Op", int'(OpCode), 5);
    check("set_stage", int'(stage), 3);
    check("set_valid", int'(valid), 1);

    // Restart from READY.
    press(4'hA, 8);
    check("rs_A", int'(A), 10);
    check("rs_stage", int'(stage), 1);
    check("rs_valid", int'(valid), 0);
    check("rs_B", int'(B), 9);
    check("rs_Op", int'(OpCode), 5);

    // Bounce then hold: exactly one capture; a 3-cycle pulse alone: none.
    sw_data = 4'hC;
    for (int k = 0; k < 2; k++) begin
      btn_load = 1'b1; ticks(2);
      btn_load = 1'b0; ticks(2);
    end
    btn_load = 1'b1; ticks(10);
    btn_load = 1'b0; ticks(DEB + 4);
    check("bnc_B", int'(B), 12);
    check("bnc_stage", int'(stage), 2);
    sw_data = 4'h6;
    btn_load = 1'b1; ticks(3);
    btn_load = 1'b0; ticks(DEB + 4);
    check("glitch_stage", int'(stage), 2);
    check("glitch_Op", int'(OpCode), 5);

    // Clear and load rising together in LOAD_OP: clear wins.
    sw_data = 4'hF; btn_load = 1'b1; btn_clear = 1'b1;
    ticks(10);
    btn_load = 1'b0; btn_clear = 1'b0;
    ticks(DEB + 4);
    check("clr_stage", int'(stage), 0);
    check("clr_A", int'(A), 0);
    check("clr_B", int'(B), 0);
    check("clr_Op", int'(OpCode), 0);
    press(4'h7, 30);
    check("hold_stage", int'(stage), 1);
    check("hold_A", int'(A), 7);

    // Randomised presses, glitches, clears and switch changes.
    for (int it = 0; it < 300; it++) begin
      int act;
      int len;
      act = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 9));
      sw_data = 4'($urandom);
      if (act < 7) btn_load = 1'b1;
      else if (act < 8) btn_clear = 1'b1;
      else begin btn_load = 1'b1; btn_clear = 1'($urandom); end
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 3) == 0) sw_data = 4'($urandom);
        tick();
      end
      btn_load = 1'b0; btn_clear = 1'b0;
      ticks(int'($urandom_range(1, 9)));
    end
    ticks(DEB + 4);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
